// File: rtl/multi_cycle_control_fsm_pkg.sv
// rtl/multi_cycle_control_fsm_pkg.sv - opcodes, state enum and control encodings for the multi-cycle sequencer
package multi_cycle_control_fsm_pkg;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] WB_ALUOUT  = 2'b00;
  localparam logic [1:0] WB_MDR     = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] PCS_PC4    = 2'b00;
  localparam logic [1:0] PCS_ALU    = 2'b01;
  localparam logic [1:0] PCS_ALUOUT = 2'b10;

  typedef struct packed {
    logic       mem_valid;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       is_halted;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Opcodes that produce an rd value; anything else reaching WB is a NOP.
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP_ARITH, OP_ARITH_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD};
  endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// rtl/mcc_output_decode.sv - combinational decode of sequencer state and opcode into datapath controls
module mcc_output_decode
  import multi_cycle_control_fsm_pkg::*;
(
  input  logic [2:0]        state,
  input  logic [6:0]        opcode,
  input  logic              bcond,
  input  logic              mem_ready,
  input  logic              halt_hit,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;
  assign ctrl = c;

  always_comb begin
    c = '0;
    case (state_t'(state))
      S_IF: begin
        c.mem_valid = 1'b1;
        c.mem_read  = 1'b1;
        c.ir_write  = mem_ready;
      end
      S_ID: begin
        c.alu_src_b = SRC_B_IMM;
        if (opcode == OP_SYSTEM && !halt_hit) begin
          c.pc_write  = 1'b1;
          c.pc_source = PCS_PC4;
        end
      end
      S_EX: begin
        case (opcode)
          OP_BRANCH: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALU_BRANCH;
            c.pc_write  = 1'b1;
            c.pc_source = bcond ? PCS_ALUOUT : PCS_PC4;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
          end
          OP_ARITH: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALU_FUNCT;
          end
          OP_ARITH_IMM: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_FUNCT;
          end
          OP_LUI: begin
            c.alu_src_a = SRC_A_ZERO;
            c.alu_src_b = SRC_B_IMM;
          end
          OP_AUIPC, OP_JAL: begin
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address and direction stay stable for the whole access, ready or not.
        c.mem_valid = 1'b1;
        c.i_or_d    = 1'b1;
        c.mem_read  = (opcode == OP_LOAD);
        c.mem_write = (opcode == OP_STORE);
        if (mem_ready) begin
          c.mdr_write = (opcode == OP_LOAD);
          c.pc_write  = (opcode == OP_STORE);
          c.pc_source = PCS_PC4;
        end
      end
      S_WB: begin
        c.reg_write = writes_rd(opcode);
        c.pc_write  = 1'b1;
        if (opcode == OP_LOAD) begin
          c.wb_sel = WB_MDR;
        end else if (opcode == OP_JAL || opcode == OP_JALR) begin
          c.wb_sel    = WB_PC4;
          c.pc_source = PCS_ALUOUT;
        end
      end
      S_HALT: c.is_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// rtl/multi_cycle_control_fsm.sv - IF/ID/EX/MEM/WB sequencer with halt latch and retired-instruction counter
module multi_cycle_control_fsm
  import multi_cycle_control_fsm_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 32,
  parameter int unsigned HALT_CODE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [XLEN-1:0]  x17_val,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             is_halted,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;
  logic   halt_hit;
  logic   retire;

  assign halt_hit = (x17_val == XLEN'(HALT_CODE));

  mcc_output_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .bcond     (bcond),
    .mem_ready (mem_ready),
    .halt_hit  (halt_hit),
    .ctrl      (ctrl_raw)
  );

  // Controls are held off while reset is asserted so an in-flight access is abandoned.
  assign ctrl   = reset ? '0 : ctrl_raw;
  assign retire = ctrl_raw.pc_write | (state == S_ID && opcode == OP_SYSTEM && halt_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IF;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_IF:  if (mem_ready) state <= S_ID;
        S_ID: begin
          if (opcode == OP_SYSTEM) state <= halt_hit ? S_HALT : S_IF;
          else                     state <= S_EX;
        end
        S_EX: begin
          case (opcode)
            OP_BRANCH:         state <= S_IF;
            OP_LOAD, OP_STORE: state <= S_MEM;
            default:           state <= S_WB;
          endcase
        end
        S_MEM: if (mem_ready) state <= (opcode == OP_LOAD) ? S_WB : S_IF;
        S_WB:   state <= S_IF;
        S_HALT: state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  assign mem_valid = ctrl.mem_valid;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign i_or_d    = ctrl.i_or_d;
  assign ir_write  = ctrl.ir_write;
  assign mdr_write = ctrl.mdr_write;
  assign reg_write = ctrl.reg_write;
  assign wb_sel    = ctrl.wb_sel;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign alu_op    = ctrl.alu_op;
  assign pc_write  = ctrl.pc_write;
  assign pc_source = ctrl.pc_source;
  assign is_halted = ctrl.is_halted;

endmodule
